// File: rtl/xfer_pkg.sv
// Shared types for the transfer-bus sequencer: post-op encodings, FSM state and request record.
package xfer_pkg;

    localparam int XFER_NREG = 8;
    localparam int XFER_ID_W = $clog2(XFER_NREG);

    typedef logic [1:0] op_t;

    localparam op_t OP_NONE = 2'b00;
    localparam op_t OP_INC  = 2'b01;
    localparam op_t OP_DEC  = 2'b10;
    localparam op_t OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        POST = 2'd2
    } state_e;

    typedef struct packed {
        logic [XFER_ID_W-1:0] src;
        logic [XFER_ID_W-1:0] dst;
        op_t                  op;
    } req_t;

    function automatic logic has_post(input op_t op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

    // A self-transfer carries no data, so an inc/dec on it skips straight to POST.
    function automatic state_e launch_state(input req_t r);
        if (r.src != r.dst)
            return XFER;
        else if (has_post(r.op))
            return POST;
        else
            return XFER;
    endfunction

endpackage

// File: rtl/xfer_bus_ctrl_if.sv
// Request port and register-strobe bundle between a requester and the transfer-bus sequencer.
interface xfer_bus_ctrl_if #(
    parameter int NREG = 8,
    parameter int ID_W = $clog2(NREG)
);
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_src;
    logic [ID_W-1:0] req_dst;
    logic [1:0]      req_op;
    logic [NREG-1:0] reg_write;
    logic [NREG-1:0] reg_load;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output req_valid, req_src, req_dst, req_op,
        input  req_ready, reg_write, reg_load, inc, dec, busy, done, err
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_op,
        output req_ready, reg_write, reg_load, inc, dec, busy, done, err
    );

endinterface

// File: rtl/xfer_req_fifo.sv
// Small synchronous FIFO holding pending bus requests; cleared asynchronously.
module xfer_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xfer_bus_ctrl.sv
// Transfer-bus sequencer: queues requests and expands each into a bus transfer plus optional post inc/dec.
module xfer_bus_ctrl
    import xfer_pkg::*;
#(
    parameter int NREG  = XFER_NREG,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    xfer_bus_ctrl_if.slave bus
);

    localparam int REQ_W = $bits(req_t);
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [REQ_W-1:0] in_bits;
    logic [REQ_W-1:0] head_bits;
    req_t             in_req;
    req_t             head;
    req_t             cmd;
    state_e           state;
    state_e           next_state;
    logic             last_cycle;

    always_comb begin
        in_req     = '0;
        in_req.src = bus.req_src;
        in_req.dst = bus.req_dst;
        in_req.op  = bus.req_op;
    end

    assign in_bits       = in_req;
    assign head          = req_t'(head_bits);
    assign bus.req_ready = clr_n && !full;
    assign push          = bus.req_valid && bus.req_ready;

    xfer_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (pop),
        .din   (in_bits),
        .data  (head_bits),
        .full  (full),
        .empty (empty)
    );

    assign last_cycle = ((state == XFER) && !has_post(cmd.op)) || (state == POST);
    assign pop        = ((state == IDLE) || last_cycle) && !empty;

    always_comb begin
        next_state = state;
        if ((state == XFER) && has_post(cmd.op))
            next_state = POST;
        else if (pop)
            next_state = launch_state(head);
        else if (last_cycle)
            next_state = IDLE;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cmd   <= '0;
        end else begin
            state <= next_state;
            if (pop)
                cmd <= head;
        end
    end

    // Strobes come only from registered state and the command register, so they hold steady
    // across the falling edge where the registers sample them.
    always_comb begin
        bus.reg_write = '0;
        bus.reg_load  = '0;
        bus.inc       = '0;
        bus.dec       = '0;
        case (state)
            XFER: begin
                if (cmd.src != cmd.dst) begin
                    bus.reg_write = ONE << cmd.src;
                    bus.reg_load  = ONE << cmd.dst;
                end
            end
            POST: begin
                if (cmd.op == OP_INC)
                    bus.inc = ONE << cmd.src;
                else
                    bus.dec = ONE << cmd.src;
            end
            default: ;
        endcase
    end

    assign bus.done = last_cycle;
    assign bus.err  = last_cycle && (cmd.op == OP_RSVD);
    assign bus.busy = (state != IDLE) || !empty;

endmodule

// File: doc/xfer_bus_ctrl.md
# xfer_bus_ctrl

Transfer-bus sequencer that drives the control side of the shared transfer bus. It drives the per-register `reg_write` (bus drive), `reg_load`, `inc` and `dec` strobes of the up/down/load registers (PC, SP, SI, DI, general registers). Requests arrive through a ready/valid port into a small FIFO. Each request is expanded into a one-cycle bus transfer, optionally followed by a one-cycle post-increment/decrement of the source register. The controller acts on rising clock edges so its strobes are stable when the registers sample on the falling edge.

## Interface
- `NREG`, 8, number of registers attached to the bus
- `ID_W`, `$clog2(NREG)`, register index width
- `DEPTH`, 4, request FIFO depth (power of two)
- `clk`  in  1  system clock; controller state changes on posedge
- `clr_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  FIFO not full
- `req_src`  in  ID_W  register that drives the bus
- `req_dst`  in  ID_W  register that loads from the bus
- `req_op`  in  2  post-op on source: 00 none, 01 inc, 10 dec, 11 reserved
- `reg_write`  out  NREG  one-hot bus-drive enable
- `reg_load`  out  NREG  one-hot load enable
- `inc`  out  NREG  one-hot increment strobe
- `dec`  out  NREG  one-hot decrement strobe
- `busy`  out  1  FIFO non-empty or command in progress
- `done`  out  1  high during the final cycle of each command
- `err`  out  1  high with `done` for a command that used `req_op`=11

## Operation
- Push happens on a posedge where `req_valid && req_ready`. `req_ready` = !full, with no same-cycle pop bypass.
- States:
  - IDLE: all strobes are 0.
  - XFER: `reg_write[src]` and `reg_load[dst]` are high.
  - POST: `inc[src]` or `dec[src]`.
- Pop and launch: in IDLE, or at the end of a command's final cycle, if the FIFO is non-empty, pop the head into the current-command register.
  - src≠dst: go to XFER.
  - src==dst and op inc/dec: go directly to POST. This is a plain register inc/dec with no transfer.
  - src==dst and op none/11: spend one XFER cycle with all strobes 0 (NOP).
- After XFER, go to POST if op is inc/dec; otherwise the command is complete.
- Post-op uses a separate cycle because the registers prioritise load over inc over dec. Same-cycle load+inc is never issued.
- Op 11 is treated as none, and `err` is raised in the done cycle.
- After the final cycle: pop the next command if one is available, else go to IDLE.
- Strobes are decoded from registered state and the command register only; no combinational path from `req_*` exists.
- All strobe vectors are at most one-hot. At most one register drives the bus.

## Timing
- Reset (async on `clr_n` low): state IDLE, FIFO empty, all strobes 0, `req_ready`=0 while in reset then 1, `busy`=0, `done`=0, `err`=0.
- Reset mid-command: strobes drop immediately, and queued requests are discarded.
- Latency: a request accepted at posedge k is popped at posedge k+1. Its first strobe is active from k+1 to k+2 and is sampled by the register at the negedge between them.
- Throughput: 1 cycle per plain transfer, 2 per transfer with post-op, back-to-back with no IDLE gap.
- `busy` is combinational from state and FIFO count. `done` and `err` are decoded from state, like the strobes.
- FIFO full: `req_ready`=0; the request is held by the sender.
- FIFO empty at command end: return to IDLE. `busy` falls in the cycle after `done`.

## Structure
- Package `xfer_pkg` holds:
  - op encodings `OP_NONE`, `OP_INC`, `OP_DEC`, `OP_RSVD`
  - state enum IDLE/XFER/POST
  - request struct {src, dst, op}
- Sub-module `xfer_req_fifo`: synchronous FIFO with parameterised DEPTH and width. Ports: push, pop, full, empty, data. Async active-low clear.

## Test plan
- Reset, then a single request src=2, dst=5, op=00 → one cycle with `reg_write`=0x04, `reg_load`=0x20, `done`=1, and latency 1 cycle after accept.
- src=1 (SP), dst=3, op=01 → XFER cycle (write 0x02, load 0x08), then POST cycle with `inc`=0x02. Bus register SP ends +1.
- src=dst=4, op=10 → a single POST cycle with `dec`=0x10. `reg_write`/`reg_load` stay 0 throughout.
- Push 5 requests back-to-back with the controller stalled → `req_ready` drops after 4. All 5 execute in order with no IDLE gap, and `busy` falls one cycle after the last `done`.
- op=11, src=0, dst=6 → transfer executes, and `err`=1 in the `done` cycle with no inc/dec.
- Assert `clr_n` low during a POST cycle with 3 queued → strobes are 0 immediately. After release: IDLE, FIFO empty, no further strobes.
